// File: rtl/accel_ctrl_if.sv
// Command, stream-beat and status bundle between the control-register block
// and the accelerator sequencer.
interface accel_ctrl_if #(
   parameter int unsigned CNT_W = 14
) ();
   logic             cmd_valid;
   logic [1:0]       cmd_op;
   logic             cmd_ready;
   logic             beat;
   logic             beat_last;
   logic             conv_done;
   logic             clr_err;
   logic [1:0]       o_state;
   logic             o_busy;
   logic             o_done;
   logic             o_err;
   logic [1:0]       o_err_code;
   logic [CNT_W-1:0] o_beat_cnt;
   logic             o_param_ok;
   logic             o_image_ok;

   modport master (
      output cmd_valid, cmd_op, beat, beat_last, conv_done, clr_err,
      input  cmd_ready, o_state, o_busy, o_done, o_err, o_err_code,
             o_beat_cnt, o_param_ok, o_image_ok
   );

   modport slave (
      input  cmd_valid, cmd_op, beat, beat_last, conv_done, clr_err,
      output cmd_ready, o_state, o_busy, o_done, o_err, o_err_code,
             o_beat_cnt, o_param_ok, o_image_ok
   );
endinterface

// File: rtl/accel_ctrl.sv
// Top-level sequencer: accepts one command at a time, drives the shared state
// bus, checks load lengths and supervises the compute phase with a timeout.
module accel_ctrl #(
   parameter int unsigned PARAM_WORDS = 12672,
   parameter int unsigned IMAGE_WORDS = 2304,
   parameter logic [19:0] TIMEOUT     = 20'd1000000,
   parameter int unsigned CNT_W       = 14
) (
   input  logic        clk,
   input  logic        rst,
   accel_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PARAM = 2'd1,
      ST_IMAGE = 2'd2,
      ST_ACCEL = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] PARAM_EXP = CNT_W'(PARAM_WORDS);
   localparam logic [CNT_W-1:0] IMAGE_EXP = CNT_W'(IMAGE_WORDS);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [19:0]      TMO_LAST  = TIMEOUT - 20'd1;

   state_t           state_r, state_nx_s;
   logic             cmd_ready_r, busy_r, done_r, err_r;
   logic [1:0]       err_code_r;
   logic [CNT_W-1:0] beat_cnt_r;
   logic             param_ok_r, image_ok_r;
   logic [19:0]      tmo_cnt_r;

   logic [CNT_W-1:0] cnt_inc_s, exp_len_s, beat_cnt_nx_s;
   logic             len_hit_s, load_end_s, load_ok_s, accept_s, start_ok_s, tmo_hit_s;
   logic             done_s, err_ev_s, err_nx_s, param_ok_nx_s, image_ok_nx_s;
   logic [1:0]       err_ev_code_s, err_code_nx_s;
   logic [19:0]      tmo_cnt_nx_s;

   // Decode phase events from the current state and inputs
   always_comb begin
      cnt_inc_s = beat_cnt_r + CNT_ONE;
      if (state_r == ST_PARAM) begin
         exp_len_s = PARAM_EXP;
      end else begin
         exp_len_s = IMAGE_EXP;
      end
      len_hit_s  = (cnt_inc_s == exp_len_s);
      load_end_s = bus.beat && (bus.beat_last || len_hit_s);
      load_ok_s  = bus.beat && bus.beat_last && len_hit_s;
      accept_s   = cmd_ready_r && bus.cmd_valid;
      start_ok_s = param_ok_r && image_ok_r;
      tmo_hit_s  = (tmo_cnt_r == TMO_LAST);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               case (bus.cmd_op)
                  2'd1:    state_nx_s = ST_PARAM;
                  2'd2:    state_nx_s = ST_IMAGE;
                  2'd3:    state_nx_s = start_ok_s ? ST_ACCEL : ST_IDLE;
                  default: state_nx_s = ST_IDLE;
               endcase
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_PARAM, ST_IMAGE: state_nx_s = load_end_s ? ST_IDLE : state_r;
         ST_ACCEL:           state_nx_s = (bus.conv_done || tmo_hit_s) ? ST_IDLE : ST_ACCEL;
         default:            state_nx_s = ST_IDLE;
      endcase
   end

   // Output/datapath next values; success has priority over timeout
   always_comb begin
      done_s        = 1'b0;
      err_ev_s      = 1'b0;
      err_ev_code_s = 2'd0;
      beat_cnt_nx_s = beat_cnt_r;
      param_ok_nx_s = param_ok_r;
      image_ok_nx_s = image_ok_r;
      tmo_cnt_nx_s  = tmo_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               case (bus.cmd_op)
                  2'd1: begin
                     param_ok_nx_s = 1'b0;
                     beat_cnt_nx_s = '0;
                  end
                  2'd2: begin
                     image_ok_nx_s = 1'b0;
                     beat_cnt_nx_s = '0;
                  end
                  2'd3: begin
                     if (start_ok_s) begin
                        tmo_cnt_nx_s = 20'd0;
                     end else begin
                        err_ev_s      = 1'b1;
                        err_ev_code_s = 2'd3;
                     end
                  end
                  default: done_s = 1'b0;
               endcase
            end else begin
               done_s = 1'b0;
            end
         end
         ST_PARAM, ST_IMAGE: begin
            if (bus.beat) begin
               beat_cnt_nx_s = cnt_inc_s;
               if (load_ok_s) begin
                  done_s = 1'b1;
                  if (state_r == ST_PARAM) begin
                     param_ok_nx_s = 1'b1;
                  end else begin
                     image_ok_nx_s = 1'b1;
                  end
               end else if (load_end_s) begin
                  err_ev_s      = 1'b1;
                  err_ev_code_s = 2'd1;
               end else begin
                  done_s = 1'b0;
               end
            end else begin
               beat_cnt_nx_s = beat_cnt_r;
            end
         end
         ST_ACCEL: begin
            tmo_cnt_nx_s = tmo_cnt_r + 20'd1;
            if (bus.conv_done) begin
               done_s        = 1'b1;
               image_ok_nx_s = 1'b0;
            end else if (tmo_hit_s) begin
               err_ev_s      = 1'b1;
               err_ev_code_s = 2'd2;
               image_ok_nx_s = 1'b0;
            end else begin
               done_s = 1'b0;
            end
         end
         default: done_s = 1'b0;
      endcase

      // First error wins unless it is being cleared in the same cycle
      if (err_ev_s && (!err_r || bus.clr_err)) begin
         err_nx_s      = 1'b1;
         err_code_nx_s = err_ev_code_s;
      end else if (bus.clr_err) begin
         err_nx_s      = 1'b0;
         err_code_nx_s = 2'd0;
      end else begin
         err_nx_s      = err_r;
         err_code_nx_s = err_code_r;
      end
   end

   // Registered outputs and datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_ready_r <= 1'b1;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         err_code_r  <= 2'd0;
         beat_cnt_r  <= '0;
         param_ok_r  <= 1'b0;
         image_ok_r  <= 1'b0;
         tmo_cnt_r   <= 20'd0;
      end else begin
         cmd_ready_r <= (state_nx_s == ST_IDLE);
         busy_r      <= (state_nx_s != ST_IDLE);
         done_r      <= done_s;
         err_r       <= err_nx_s;
         err_code_r  <= err_code_nx_s;
         beat_cnt_r  <= beat_cnt_nx_s;
         param_ok_r  <= param_ok_nx_s;
         image_ok_r  <= image_ok_nx_s;
         tmo_cnt_r   <= tmo_cnt_nx_s;
      end
   end

   assign bus.cmd_ready  = cmd_ready_r;
   assign bus.o_state    = state_r;
   assign bus.o_busy     = busy_r;
   assign bus.o_done     = done_r;
   assign bus.o_err      = err_r;
   assign bus.o_err_code = err_code_r;
   assign bus.o_beat_cnt = beat_cnt_r;
   assign bus.o_param_ok = param_ok_r;
   assign bus.o_image_ok = image_ok_r;
endmodule

// File: tb/tb_accel_ctrl.sv
// Randomized bench for accel_ctrl: transactions are scored against a
// transaction-level model of the command / load / compute rules.
module tb_accel_ctrl;
   localparam int PW  = 12672;
   localparam int IW  = 2304;
   localparam int TMO = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   done_seen = 0;

   // Reference model: phase, flags, sticky error, last load length
   int   m_state = 0;
   int   m_code  = 0;
   int   m_cnt   = 0;
   bit   m_pok   = 1'b0;
   bit   m_iok   = 1'b0;
   bit   m_err   = 1'b0;

   accel_ctrl_if #(.CNT_W(14)) bus ();

   accel_ctrl #(
      .PARAM_WORDS(PW),
      .IMAGE_WORDS(IW),
      .TIMEOUT(20'd100),
      .CNT_W(14)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.o_done === 1'b1) done_seen <= done_seen + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'd0;
      bus.beat      = 1'b0;
      bus.beat_last = 1'b0;
      bus.conv_done = 1'b0;
      bus.clr_err   = 1'b0;
   endtask

   task automatic model_err(input int code);
      if (!m_err) begin
         m_err  = 1'b1;
         m_code = code;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".state"}, bus.o_state, m_state);
      chk({tag, ".ready"}, bus.cmd_ready, (m_state == 0));
      chk({tag, ".busy"}, bus.o_busy, (m_state != 0));
      chk({tag, ".err"}, bus.o_err, m_err);
      chk({tag, ".code"}, bus.o_err_code, m_code);
      chk({tag, ".cnt"}, bus.o_beat_cnt, m_cnt);
      chk({tag, ".pok"}, bus.o_param_ok, m_pok);
      chk({tag, ".iok"}, bus.o_image_ok, m_iok);
   endtask

   task automatic model_reset();
      m_state = 0; m_code = 0; m_cnt = 0;
      m_pok = 1'b0; m_iok = 1'b0; m_err = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      check_all("reset");
      chk("reset.done", bus.o_done, 0);
   endtask

   task automatic send_cmd(input int op);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op[1:0];
      tick();
      idle_inputs();
      case (op)
         1: begin m_state = 1; m_pok = 1'b0; m_cnt = 0; end
         2: begin m_state = 2; m_iok = 1'b0; m_cnt = 0; end
         3: if (m_pok && m_iok) m_state = 3; else model_err(3);
         default: ;
      endcase
      check_all("cmd");
      chk("cmd.done", bus.o_done, 0);
   endtask

   // Stream beats until the model says the load ends; last_pos==0 means no tlast
   task automatic load(input int last_pos);
      int  exp_len;
      int  k;
      bit  b;
      bit  ended;
      exp_len = (m_state == 1) ? PW : IW;
      k = 0;
      ended = 1'b0;
      while (!ended) begin
         b = ($urandom_range(0, 7) != 0);
         bus.conv_done = ($urandom_range(0, 15) == 0);
         bus.cmd_valid = ($urandom_range(0, 15) == 0);
         bus.cmd_op    = 2'($urandom);
         if (b) begin
            k++;
            bus.beat      = 1'b1;
            bus.beat_last = (k == last_pos);
         end else begin
            bus.beat      = 1'b0;
            bus.beat_last = 1'($urandom);
         end
         tick();
         idle_inputs();
         if (b && (k == last_pos || k == exp_len)) begin
            ended = 1'b1;
         end else begin
            chk("load.state", bus.o_state, m_state);
            chk("load.cnt", bus.o_beat_cnt, k);
         end
      end
      m_cnt = k;
      if (k == last_pos && k == exp_len) begin
         if (m_state == 1) m_pok = 1'b1; else m_iok = 1'b1;
         chk("load.done", bus.o_done, 1);
      end else begin
         model_err(1);
         chk("load.nodone", bus.o_done, 0);
      end
      m_state = 0;
      check_all("load.end");
      tick();
      chk("load.pulse", bus.o_done, 0);
   endtask

   // Compute phase; conv_done on cycle done_at (1-based), never if outside 1..TMO
   task automatic accel(input int done_at);
      int c;
      bit ended;
      c = 0;
      ended = 1'b0;
      while (!ended) begin
         c++;
         bus.conv_done = (c == done_at);
         bus.beat      = 1'($urandom);
         bus.beat_last = 1'($urandom);
         bus.cmd_valid = ($urandom_range(0, 7) == 0);
         bus.cmd_op    = 2'($urandom);
         tick();
         idle_inputs();
         if (c == done_at || c >= TMO) begin
            ended = 1'b1;
         end else begin
            chk("accel.state", bus.o_state, 3);
            chk("accel.cnt", bus.o_beat_cnt, m_cnt);
         end
      end
      m_state = 0;
      m_iok = 1'b0;
      if (c == done_at) begin
         chk("accel.done", bus.o_done, 1);
      end else begin
         model_err(2);
         chk("accel.nodone", bus.o_done, 0);
      end
      check_all("accel.end");
      tick();
      chk("accel.pulse", bus.o_done, 0);
   endtask

   task automatic clear();
      bus.clr_err = 1'b1;
      tick();
      idle_inputs();
      m_err = 1'b0;
      m_code = 0;
      check_all("clear");
   endtask

   initial begin
      int op;
      int snap;
      idle_inputs();
      do_reset();

      send_cmd(1); load(PW);
      send_cmd(2); load(2000);
      send_cmd(3);
      clear();
      send_cmd(3);
      clear();
      send_cmd(2); load(IW);
      send_cmd(3); accel(50);
      send_cmd(3);
      clear();
      send_cmd(2); load(IW);
      send_cmd(3); accel(0);

      // Clear coincident with a new error: the new error is latched
      bus.clr_err = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_op = 2'd3;
      tick();
      idle_inputs();
      m_err = 1'b1; m_code = 3;
      check_all("clr_new");
      clear();

      send_cmd(2); load(IW);
      send_cmd(3); accel(TMO);
      send_cmd(2); load(0);
      clear();
      send_cmd(0);

      for (int it = 0; it < 12; it++) begin
         if (m_err && $urandom_range(0, 2) == 0) clear();
         case ($urandom_range(0, 5))
            0: op = 0;
            1: op = ($urandom_range(0, 3) == 0) ? 1 : 2;
            2, 3: op = 2;
            default: op = 3;
         endcase
         send_cmd(op);
         if (m_state == 1) load($urandom_range(1, 300));
         else if (m_state == 2) load(($urandom_range(0, 1) == 1) ? IW : $urandom_range(0, IW + 5));
         else if (m_state == 3) accel($urandom_range(1, TMO + 20));
      end

      // Reset in the middle of a parameter load
      send_cmd(1);
      for (int i = 1; i < 50; i++) begin
         bus.beat = 1'b1;
         tick();
         idle_inputs();
         chk("pre_rst.cnt", bus.o_beat_cnt, i);
      end
      bus.beat = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle_inputs();
      model_reset();
      check_all("mid_rst");
      chk("mid_rst.done", bus.o_done, 0);
      snap = done_seen;
      tick();
      chk("mid_rst.pulses", done_seen, snap);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
